// File: rtl/y_pulse_monitor.sv
// Synchronises the asynchronous Y level, strobes its edges, counts rising edges and
// measures each high pulse, handing completed widths out over a single-entry valid/ready port.
module y_pulse_monitor #(
    parameter int CNT_W       = 8,
    parameter int PW_W        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y_in,
    input  logic             clear,
    output logic             y_sync,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic             pw_valid,
    input  logic             pw_ready,
    output logic [PW_W-1:0]  pw_data,
    output logic             pw_sat,
    output logic             overrun
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        LOW      = 2'd1,
        HIGH     = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   y_prev_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   primed;
    logic [PW_W-1:0]        width_q, width_d;
    logic                   wsat_q, wsat_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   vld_q, vld_d;
    logic [PW_W-1:0]        data_q, data_d;
    logic                   sat_q, sat_d;
    logic                   ovr_q, ovr_d;
    logic                   publish;

    // Edges are only trusted once y_sync and y_prev both hold real samples of Y,
    // so the reset zeros in the chain never look like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            y_prev_q <= 1'b0;
            prime_q  <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], y_in};
            y_prev_q <= sync_q[SYNC_STAGES-1];
            prime_q  <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign primed     = prime_q[SYNC_STAGES];
    assign y_sync     = sync_q[SYNC_STAGES-1];
    assign rise_pulse = primed & y_sync & ~y_prev_q;
    assign fall_pulse = primed & ~y_sync & y_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = WAIT_LOW;
        end else begin
            case (state_q)
                WAIT_LOW: if (primed && !y_sync) state_d = LOW;
                LOW:      if (rise_pulse) state_d = HIGH;
                HIGH:     if (fall_pulse) state_d = LOW;
                default:  state_d = WAIT_LOW;
            endcase
        end
    end

    always_comb begin
        publish = (state_q == HIGH) && fall_pulse && !clear;
        width_d = width_q;
        wsat_d  = wsat_q;
        if (!clear && state_q == LOW && rise_pulse) begin
            width_d = PW_W'(1);
            wsat_d  = 1'b0;
        end else if (!clear && state_q == HIGH && y_sync) begin
            if (width_q == '1) wsat_d = 1'b1;
            else               width_d = width_q + 1'b1;
        end

        cnt_d  = cnt_q;
        vld_d  = vld_q;
        data_d = data_q;
        sat_d  = sat_q;
        ovr_d  = ovr_q;
        if (clear) begin
            cnt_d = '0;
            vld_d = 1'b0;
            ovr_d = 1'b0;
        end else begin
            if (rise_pulse && cnt_q != '1) cnt_d = cnt_q + 1'b1;
            // A result may replace the held one only when that one leaves this very cycle.
            if (publish) begin
                if (!vld_q || pw_ready) begin
                    vld_d  = 1'b1;
                    data_d = width_q;
                    sat_d  = wsat_q;
                end else begin
                    ovr_d = 1'b1;
                end
            end else if (vld_q && pw_ready) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q <= '0;
            wsat_q  <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            width_q <= width_d;
            wsat_q  <= wsat_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign event_count = cnt_q;
    assign pw_valid    = vld_q;
    assign pw_data     = data_q;
    assign pw_sat      = sat_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_y_pulse_monitor.sv
// Directed bench for y_pulse_monitor (CNT_W=3, PW_W=4) with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_y_pulse_monitor;

    localparam int CNT_W = 3;
    localparam int PW_W  = 4;
    localparam int CMAX  = 7;
    localparam int PWMAX = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             y_in = 1'b1;
    logic             clear = 1'b0;
    logic             pw_ready = 1'b0;
    logic             y_sync, rise_pulse, fall_pulse;
    logic [CNT_W-1:0] event_count;
    logic             pw_valid;
    logic [PW_W-1:0]  pw_data;
    logic             pw_sat;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    y_pulse_monitor #(.CNT_W(CNT_W), .PW_W(PW_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .clear(clear),
        .y_sync(y_sync), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .event_count(event_count), .pw_valid(pw_valid), .pw_ready(pw_ready),
        .pw_data(pw_data), .pw_sat(pw_sat), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of Y samples plus an unbounded pulse length.
    bit hist[$];
    int m_cnt, m_len, m_data;
    bit m_valid, m_ovr, m_armed, m_inp, m_sat;

    function automatic bit m_ys();
        return (hist.size() >= 2) ? hist[1] : 1'b0;
    endfunction
    function automatic bit m_primed();
        return hist.size() >= 3;
    endfunction
    function automatic bit m_rise();
        return m_primed() && hist[1] && !hist[2];
    endfunction
    function automatic bit m_fall();
        return m_primed() && !hist[1] && hist[2];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_cnt = 0; m_len = 0; m_data = 0;
            m_valid = 0; m_ovr = 0; m_armed = 0; m_inp = 0; m_sat = 0;
        end else begin : model_step
            bit ys, rise, pub;
            ys   = m_ys();
            rise = m_rise();
            pub  = 0;
            if (clear) begin
                m_cnt = 0; m_ovr = 0; m_valid = 0; m_armed = 0; m_inp = 0;
            end else begin
                if (rise && m_cnt < CMAX) m_cnt++;
                if (!m_armed) begin
                    if (m_primed() && !ys) m_armed = 1;
                end else if (m_inp) begin
                    if (ys) m_len++;
                    else begin pub = 1; m_inp = 0; end
                end else if (rise) begin
                    m_inp = 1; m_len = 1;
                end
                if (pub) begin
                    if (!m_valid || pw_ready) begin
                        m_data  = (m_len > PWMAX) ? PWMAX : m_len;
                        m_sat   = (m_len > PWMAX);
                        m_valid = 1;
                    end else begin
                        m_ovr = 1;
                    end
                end else if (m_valid && pw_ready) begin
                    m_valid = 0;
                end
            end
            hist.push_front(y_in);
            if (hist.size() > 3) void'(hist.pop_back());
        end
    end

    int xfer_n = 0;
    int xfer_data = -1;
    int xfer_sat = -1;
    int vld_cycles = 0;

    always @(negedge clk) begin
        chk("y_sync", y_sync, m_ys());
        chk("rise_pulse", rise_pulse, m_rise());
        chk("fall_pulse", fall_pulse, m_fall());
        chk("event_count", event_count, m_cnt);
        chk("pw_valid", pw_valid, m_valid);
        chk("overrun", overrun, m_ovr);
        if (m_valid || !rst_n) begin
            chk("pw_data", pw_data, m_data);
            chk("pw_sat", pw_sat, m_sat);
        end
        if (pw_valid) vld_cycles++;
        if (pw_valid && pw_ready) begin
            xfer_n++;
            xfer_data = pw_data;
            xfer_sat  = pw_sat;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int len, input int gap);
        y_in = 1'b1;
        tick(len);
        y_in = 1'b0;
        tick(gap);
    endtask

    int xn;

    initial begin
        // Reset with Y already high: the pulse in progress must be ignored.
        tick(3);
        chk("lit_reset_valid", pw_valid, 0);
        chk("lit_reset_data", pw_data, 0);
        rst_n = 1'b1;
        tick(10);
        y_in = 1'b0;
        tick(6);
        chk("lit_waitlow_valid", pw_valid, 0);
        chk("lit_waitlow_count", event_count, 0);
        chk("lit_waitlow_ovr", overrun, 0);
        chk("lit_waitlow_xfers", xfer_n, 0);

        // 5-cycle pulse with consumer always ready.
        pw_ready = 1'b1;
        vld_cycles = 0;
        y_in = 1'b1;
        tick(1);
        chk("lit_rise_early", rise_pulse, 0);
        tick(1);
        chk("lit_rise_2cyc", rise_pulse, 1);
        tick(3);
        y_in = 1'b0;
        tick(6);
        chk("lit_p5_data", xfer_data, 5);
        chk("lit_p5_sat", xfer_sat, 0);
        chk("lit_p5_count", event_count, 1);
        chk("lit_p5_vld_cycles", vld_cycles, 1);

        // Width saturation at 15.
        pulse(20, 6);
        chk("lit_p20_data", xfer_data, 15);
        chk("lit_p20_sat", xfer_sat, 1);

        // Overrun: 3 then 4 with consumer stalled.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        pw_ready = 1'b0;
        pulse(3, 2);
        pulse(4, 6);
        chk("lit_ovr_valid", pw_valid, 1);
        chk("lit_ovr_data", pw_data, 3);
        chk("lit_ovr_flag", overrun, 1);
        chk("lit_ovr_count", event_count, 2);
        pw_ready = 1'b1;
        tick(1);
        chk("lit_drain_valid", pw_valid, 0);
        chk("lit_drain_data", xfer_data, 3);

        // Publish coinciding with a transfer: new value with no gap.
        pw_ready = 1'b0;
        pulse(2, 4);
        chk("lit_hold2_data", pw_data, 2);
        y_in = 1'b1;
        tick(3);
        y_in = 1'b0;
        tick(2);
        chk("lit_fall_cycle", fall_pulse, 1);
        pw_ready = 1'b1;
        tick(1);
        chk("lit_nogap_valid", pw_valid, 1);
        chk("lit_nogap_data", pw_data, 3);
        chk("lit_nogap_prev", xfer_data, 2);
        tick(3);
        chk("lit_nogap_xfer", xfer_data, 3);

        // Event counter saturation at 7, 1-cycle pulses.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        for (int i = 0; i < 9; i++) pulse(1, 2);
        tick(3);
        chk("lit_sat_count", event_count, 7);
        chk("lit_p1_data", xfer_data, 1);
        pw_ready = 1'b0;
        pulse(2, 3);
        pulse(2, 3);
        chk("lit_pre_clear_ovr", overrun, 1);
        chk("lit_pre_clear_valid", pw_valid, 1);

        // clear in the same cycle as a rise.
        y_in = 1'b1;
        tick(2);
        chk("lit_clear_rise", rise_pulse, 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("lit_clear_count", event_count, 0);
        chk("lit_clear_ovr", overrun, 0);
        chk("lit_clear_valid", pw_valid, 0);
        tick(3);
        y_in = 1'b0;
        tick(6);
        chk("lit_after_clear_valid", pw_valid, 0);
        chk("lit_after_clear_count", event_count, 0);

        // Reset mid-pulse at width 6.
        pw_ready = 1'b1;
        y_in = 1'b1;
        tick(8);
        xn = xfer_n;
        rst_n = 1'b0;
        #1;
        chk("lit_rst_ysync", y_sync, 0);
        chk("lit_rst_count", event_count, 0);
        chk("lit_rst_valid", pw_valid, 0);
        chk("lit_rst_ovr", overrun, 0);
        tick(1);
        rst_n = 1'b1;
        tick(5);
        y_in = 1'b0;
        tick(6);
        chk("lit_abort_xfers", xfer_n, xn);
        chk("lit_abort_count", event_count, 0);
        pulse(4, 6);
        chk("lit_post_rst_data", xfer_data, 4);
        chk("lit_post_rst_count", event_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
